// File: rtl/onehot_sequence_checker.sv
// onehot_sequence_checker
// Watches a one-hot count bus and checks that each sample is a legal one-hot
// code. Each legal sample must either hold the reference position or advance
// it by one, wrapping from the MSB back to the LSB. The block tracks lock
// status and keeps a saturating count of error events. All outputs are
// registered, so results appear one cycle after the sample.
module onehot_sequence_checker #(
  parameter  int WIDTH    = 8,
  parameter  int LOCK_CNT = 4,
  parameter  int ERRW     = 8,
  localparam int IDXW     = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_step,
  input  logic [WIDTH-1:0] onehot_in,
  input  logic             clear_err,
  output logic [IDXW-1:0]  index,
  output logic             index_valid,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERRW-1:0]  err_count
);

  // good_cnt only has to reach LOCK_CNT, so size it for that value
  localparam int GCW = ($clog2(LOCK_CNT + 1) > 1) ? $clog2(LOCK_CNT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQ,
    ST_LOCKED
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] ref_q, ref_d;
  logic [GCW-1:0]  good_cnt_q, good_cnt_d;
  logic [IDXW-1:0] index_q, index_d;
  logic            index_valid_q, index_valid_d;
  logic            onehot_err_q, onehot_err_d;
  logic            seq_err_q, seq_err_d;
  logic            wrap_q, wrap_d;
  logic            locked_q, locked_d;
  logic [ERRW-1:0] err_count_q, err_count_d;

  logic            seen_bit;
  logic            multi_bit;
  logic            legal;
  logic [IDXW-1:0] sample_idx;
  logic [IDXW-1:0] expected_idx;
  logic            seq_match;
  logic            at_top;
  logic            err_event;

  // Decode the bus: legal means exactly one bit set; sample_idx is its position
  always_comb begin
    seen_bit   = 1'b0;
    multi_bit  = 1'b0;
    sample_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (onehot_in[i]) begin
        multi_bit  = multi_bit | seen_bit;
        seen_bit   = 1'b1;
        sample_idx = IDXW'(i);
      end
    end
    legal = seen_bit & ~multi_bit;
  end

  // Work out the position the sample should show, relative to the reference
  always_comb begin
    at_top       = (ref_q == IDXW'(WIDTH - 1));
    expected_idx = ref_q;
    if (in_step) begin
      expected_idx = at_top ? '0 : (ref_q + IDXW'(1));
    end
    seq_match = (sample_idx == expected_idx);
  end

  // FSM next state, reference tracking and the next values of the outputs
  always_comb begin
    state_d       = state_q;
    ref_d         = ref_q;
    good_cnt_d    = good_cnt_q;
    index_d       = index_q;
    index_valid_d = 1'b0;
    onehot_err_d  = 1'b0;
    seq_err_d     = 1'b0;
    wrap_d        = 1'b0;
    err_event     = 1'b0;

    if (in_valid) begin
      if (!legal) begin
        onehot_err_d = 1'b1;
        err_event    = 1'b1;
        state_d      = ST_IDLE;
      end else begin
        index_valid_d = 1'b1;
        index_d       = sample_idx;
        ref_d         = sample_idx;
        case (state_q)
          ST_IDLE: begin
            good_cnt_d = '0;
            state_d    = ST_ACQ;
          end
          ST_ACQ, ST_LOCKED: begin
            if (seq_match) begin
              wrap_d = in_step & at_top;
              if (state_q == ST_ACQ) begin
                good_cnt_d = good_cnt_q + GCW'(1);
                if (good_cnt_d == GCW'(LOCK_CNT)) begin
                  state_d = ST_LOCKED;
                end
              end
            end else begin
              seq_err_d  = 1'b1;
              err_event  = 1'b1;
              good_cnt_d = '0;
              state_d    = ST_ACQ;
            end
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end

    locked_d = (state_d == ST_LOCKED);

    // clear_err beats a same-cycle error; it also acts on cycles with no sample
    err_count_d = err_count_q;
    if (clear_err) begin
      err_count_d = '0;
    end else if (err_event && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERRW'(1);
    end
  end

  // State and output registers, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ref_q         <= '0;
      good_cnt_q    <= '0;
      index_q       <= '0;
      index_valid_q <= 1'b0;
      onehot_err_q  <= 1'b0;
      seq_err_q     <= 1'b0;
      wrap_q        <= 1'b0;
      locked_q      <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      ref_q         <= ref_d;
      good_cnt_q    <= good_cnt_d;
      index_q       <= index_d;
      index_valid_q <= index_valid_d;
      onehot_err_q  <= onehot_err_d;
      seq_err_q     <= seq_err_d;
      wrap_q        <= wrap_d;
      locked_q      <= locked_d;
      err_count_q   <= err_count_d;
    end
  end

  assign index       = index_q;
  assign index_valid = index_valid_q;
  assign onehot_err  = onehot_err_q;
  assign seq_err     = seq_err_q;
  assign wrap        = wrap_q;
  assign locked      = locked_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_onehot_sequence_checker.sv
// Testbench for onehot_sequence_checker.
// A behavioural model predicts each cycle's registered outputs, and the
// prediction is queued. A monitor process pops one prediction after every
// rising edge and compares it with the DUT outputs.
module tb_onehot_sequence_checker;

  localparam int WIDTH    = 8;
  localparam int LOCK_CNT = 4;
  localparam int ERRW     = 8;
  localparam int IDXW     = 3;
  localparam int ERR_MAX  = (1 << ERRW) - 1;

  typedef struct packed {
    logic [IDXW-1:0] index;
    logic            index_valid;
    logic            onehot_err;
    logic            seq_err;
    logic            wrap;
    logic            locked;
    logic [ERRW-1:0] err_count;
  } obs_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_step;
  logic [WIDTH-1:0] onehot_in;
  logic             clear_err;
  logic [IDXW-1:0]  index;
  logic             index_valid;
  logic             onehot_err;
  logic             seq_err;
  logic             wrap;
  logic             locked;
  logic [ERRW-1:0]  err_count;

  int   checks   = 0;
  int   failures = 0;
  int   cycle_no = 0;
  obs_t exp_q[$];

  // Model state, kept in the spec's own terms
  int m_mode;       // 0 = no reference, 1 = acquiring, 2 = locked
  int m_ref;
  int m_good;
  int m_index;
  int m_err;

  onehot_sequence_checker #(
    .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERRW(ERRW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_step(in_step),
    .onehot_in(onehot_in), .clear_err(clear_err), .index(index),
    .index_valid(index_valid), .onehot_err(onehot_err), .seq_err(seq_err),
    .wrap(wrap), .locked(locked), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t sample_dut();
    obs_t o;
    o.index       = index;
    o.index_valid = index_valid;
    o.onehot_err  = onehot_err;
    o.seq_err     = seq_err;
    o.wrap        = wrap;
    o.locked      = locked;
    o.err_count   = err_count;
    return o;
  endfunction

  task automatic check_output(input string name, input obs_t e);
    obs_t a;
    a = sample_dut();
    checks++;
    if (a !== e) begin
      failures++;
      $display("[TB] FAIL %s: got idx=%0d iv=%b ohe=%b se=%b wrap=%b lock=%b errc=%0d, want idx=%0d iv=%b ohe=%b se=%b wrap=%b lock=%b errc=%0d",
               name, a.index, a.index_valid, a.onehot_err, a.seq_err, a.wrap, a.locked, a.err_count,
               e.index, e.index_valid, e.onehot_err, e.seq_err, e.wrap, e.locked, e.err_count);
    end
  endtask

  function automatic void model_reset();
    m_mode  = 0;
    m_ref   = 0;
    m_good  = 0;
    m_index = 0;
    m_err   = 0;
  endfunction

  // Apply the checker rules to one sample and return the outputs expected next cycle
  function automatic obs_t model_step(input logic v, input logic st,
                                      input logic [WIDTH-1:0] oh, input logic clr);
    obs_t e;
    int   idx;
    int   want;
    bit   err_ev;
    e      = '0;
    err_ev = 0;
    if (v) begin
      if ($countones(oh) != 1) begin
        e.onehot_err = 1'b1;
        err_ev       = 1;
        m_mode       = 0;
      end else begin
        idx           = $clog2(oh);
        e.index_valid = 1'b1;
        m_index       = idx;
        want          = st ? (m_ref + 1) % WIDTH : m_ref;
        if (m_mode == 0) begin
          m_good = 0;
          m_mode = 1;
        end else if (idx == want) begin
          e.wrap = st && (m_ref == WIDTH - 1);
          if (m_mode == 1) begin
            m_good++;
            if (m_good == LOCK_CNT) m_mode = 2;
          end
        end else begin
          e.seq_err = 1'b1;
          err_ev    = 1;
          m_good    = 0;
          m_mode    = 1;
        end
        m_ref = idx;
      end
    end
    if (clr) m_err = 0;
    else if (err_ev && m_err < ERR_MAX) m_err++;
    e.index     = IDXW'(m_index);
    e.locked    = (m_mode == 2);
    e.err_count = ERRW'(m_err);
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the DUT should show after the edge
  task automatic apply_stimulus(input logic v, input logic st,
                                input logic [WIDTH-1:0] oh, input logic clr);
    @(negedge clk);
    in_valid  = v;
    in_step   = st;
    onehot_in = oh;
    clear_err = clr;
    exp_q.push_back(model_step(v, st, oh, clr));
  endtask

  // Assert reset mid-stream; outputs must clear without waiting for a clock edge
  task automatic pulse_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    in_step   = 1'b0;
    onehot_in = '0;
    clear_err = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_output("async_reset", obs_t'(0));
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: after each rising edge compare the oldest prediction with the DUT
  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output($sformatf("cycle%0d", cycle_no), e);
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] oh;
    int a;
    int b;
    int r;
    model_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_step   = 1'b0;
    onehot_in = '0;
    clear_err = 1'b0;
    #1;
    check_output("reset_state", obs_t'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Acquire and lock, then wrap from the MSB position to the LSB position
    apply_stimulus(1, 0, 8'h01, 0);
    for (int i = 1; i < WIDTH; i++) apply_stimulus(1, 1, WIDTH'(1 << i), 0);
    apply_stimulus(1, 1, 8'h01, 0);
    apply_stimulus(1, 0, 8'h01, 0);
    apply_stimulus(0, 1, 8'h40, 0);

    // Illegal codes while locked drop back to no reference
    apply_stimulus(1, 1, 8'h03, 0);
    apply_stimulus(1, 0, 8'h00, 0);
    apply_stimulus(1, 0, 8'h08, 0);

    // Lock again at 0x08, then a skipped position and a relock from 0x20
    for (int i = 4; i < 8; i++) apply_stimulus(1, 1, WIDTH'(1 << i), 0);
    apply_stimulus(1, 0, 8'h80, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(1, 1, WIDTH'(1 << i), 0);
    apply_stimulus(1, 1, 8'h20, 0);
    apply_stimulus(1, 1, 8'h40, 0);
    apply_stimulus(1, 1, 8'h80, 0);
    apply_stimulus(1, 1, 8'h01, 0);
    apply_stimulus(1, 1, 8'h02, 0);

    // Reset while locked
    pulse_reset();

    // Saturate the error counter, then clear it together with a sequence error
    for (int i = 0; i < 260; i++) apply_stimulus(1, 0, 8'h00, 0);
    apply_stimulus(1, 0, 8'h01, 0);
    apply_stimulus(1, 1, 8'h10, 1);
    apply_stimulus(1, 1, 8'h20, 0);

    // Random traffic, biased toward correct steps so locking happens often
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) pulse_reset();
      r = $urandom_range(0, 11);
      if (r == 0) begin
        apply_stimulus(0, 1'($urandom_range(0, 1)), WIDTH'($urandom), 0);
      end else if (r == 1) begin
        if ($urandom_range(0, 1) == 0) oh = '0;
        else begin
          a  = $urandom_range(0, WIDTH - 1);
          b  = (a + 1 + $urandom_range(0, WIDTH - 2)) % WIDTH;
          oh = WIDTH'((1 << a) | (1 << b));
        end
        apply_stimulus(1, 1'($urandom_range(0, 1)), oh, 1'($urandom_range(0, 15) == 0));
      end else if (r == 2) begin
        apply_stimulus(1, 1'($urandom_range(0, 1)), WIDTH'(1 << $urandom_range(0, WIDTH - 1)),
                       1'($urandom_range(0, 15) == 0));
      end else if (r == 3) begin
        apply_stimulus(1, 0, WIDTH'(1 << m_ref), 0);
      end else begin
        apply_stimulus(1, 1, WIDTH'(1 << ((m_ref + 1) % WIDTH)), 0);
      end
    end

    apply_stimulus(0, 0, '0, 0);
    apply_stimulus(0, 0, '0, 0);
    repeat (3) @(negedge clk);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending predictions, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_sequence_checker.md
# onehot_sequence_checker

Receive-side companion to the team's parameterized one-hot counter. It samples a one-hot count bus, decodes it to a binary index, checks that every sample is a legal one-hot code and that consecutive samples either hold or advance by exactly one position with MSB-to-LSB wrap, and tracks lock status and a saturating error count. It sits on the monitored side of any one-hot counter/sequencer and reports to status/interrupt logic.

## Interface
- WIDTH, 8: one-hot bus width; ≥2. IDXW = max(1, clog2(WIDTH)) is derived, not a parameter.
- LOCK_CNT, 4: consecutive correct steps in ACQ required to enter LOCKED; ≥1.
- ERRW, 8: err_count width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  onehot_in/in_step are sampled this cycle.
- in_step  in  1  1: sample must be next position after reference; 0: must equal reference.
- onehot_in  in  WIDTH  monitored one-hot bus.
- clear_err  in  1  synchronous clear of err_count.
- index  out  IDXW  binary index of last legal sample.
- index_valid  out  1  pulse: last sample was legal one-hot.
- onehot_err  out  1  pulse: last sample had popcount ≠ 1.
- seq_err  out  1  pulse: legal sample did not match expected index.
- wrap  out  1  pulse: legal correct step from index WIDTH-1 to 0.
- locked  out  1  level: FSM in LOCKED.
- err_count  out  ERRW  saturating count of onehot_err + seq_err events.

## Operation
- Legal sample: popcount(onehot_in) == 1; idx = bit position. Expected = in_step ? (ref == WIDTH-1 ? 0 : ref+1) : ref.
- States: IDLE (no reference), ACQ (reference held, good_cnt counting), LOCKED.
- IDLE: legal -> ref=idx, good_cnt=0, go ACQ; no seq check. Illegal -> onehot_err, stay IDLE.
- ACQ: legal & idx==expected -> ref=idx, good_cnt+1; if new good_cnt == LOCK_CNT go LOCKED. Legal mismatch -> seq_err, ref=idx, good_cnt=0, stay ACQ. Illegal -> onehot_err, go IDLE.
- LOCKED: legal match -> ref=idx, stay. Legal mismatch -> seq_err, ref=idx, good_cnt=0, go ACQ. Illegal -> onehot_err, go IDLE.
- in_valid=0: state, ref, good_cnt, index, locked, err_count unchanged; all pulses 0.
- index updates only on legal samples (illegal samples keep the prior index). wrap only when the sample is a correct in_step=1 step in ACQ/LOCKED from WIDTH-1 to 0.
- onehot_err and seq_err are mutually exclusive in a cycle; each error event adds 1 to err_count, saturating at 2^ERRW-1.
- clear_err has priority: err_count=0 that edge, even if an error occurs in the same cycle; the error pulse itself still fires.

## Timing
- All outputs registered; sample on edge N -> index/pulses/locked/err_count visible after edge N (1-cycle latency). Pulses last exactly one cycle.
- locked rises after the edge capturing the LOCK_CNT-th correct step; falls after the edge capturing the first error.
- Reset (async, any time, including mid-LOCKED): state IDLE, ref=0, good_cnt=0, index=0, index_valid=onehot_err=seq_err=wrap=locked=0, err_count=0. First sample after release treated as from IDLE.
- Back-to-back in_valid every cycle fully supported; no backpressure.

## Test plan
- Reset: assert rst_n=0 mid-traffic -> all outputs 0 immediately, locked=0, err_count=0.
- Lock (WIDTH=8, LOCK_CNT=4): 0x01 step0, then 0x02,0x04,0x08,0x10 step1 -> index_valid each, no errors, locked=1 after 5th sample, index=4.
- Wrap: locked at 0x80, sample 0x01 step1 -> wrap=1, index=0, locked stays 1; 0x01 step0 -> no error.
- One-hot error: locked, sample 0x03 then 0x00 -> onehot_err each, locked=0, index unchanged, err_count=2, state IDLE (next legal sample enters ACQ with no seq_err).
- Sequence error: locked at 0x08, sample 0x20 step1 -> seq_err, locked=0, index=5, err_count+1; then 4 correct steps from 0x20 -> relocks.
- Saturation/clear: force 260 errors -> err_count=255; clear_err with simultaneous seq_err -> seq_err pulse, err_count=0.
